// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
//   Shared definitions for the single-cycle RV32I core: opcode and funct3
//   encodings, the ALU operation enum, the default reset pc, and small
//   helper functions for the ALU and the branch comparator.
//   No ports; imported by core_single and core_regfile.
// ----------------------------------------------------------------------------
package core_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Major opcodes handled by this core. Everything else retires as a no-op.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 for OP / OP-IMM
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct3 for BRANCH
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct7 values that select the alternate (SUB/SRA) operation
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    // Map funct3 (plus the funct7[5] alternate bit) onto an ALU operation.
    // The caller is responsible for only asserting alt where it is legal.
    function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] alu_exec(input alu_op_e op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
            ALU_SLTU: r = {31'd0, (a < b)};
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $signed(a) >>> b[4:0];
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            default:  r = 32'd0;
        endcase
        return r;
    endfunction

    // Branch condition for a legal branch funct3 (010/011 are filtered out by
    // the decoder before this result is used).
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic t;
        case (f3)
            F3_BEQ:  t = (a == b);
            F3_BNE:  t = (a != b);
            F3_BLT:  t = ($signed(a) <  $signed(b));
            F3_BGE:  t = ($signed(a) >= $signed(b));
            F3_BLTU: t = (a <  b);
            F3_BGEU: t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/core_regfile.sv
// ----------------------------------------------------------------------------
// core_regfile
//   32 x 32-bit integer register file. x0 always reads as zero and is never
//   written. Three combinational read ports (rs1, rs2, debug) and one
//   synchronous write port. All registers clear on the asynchronous
//   active-low reset.
// Ports
//   clk       in   clock, write on rising edge
//   rst       in   asynchronous active-low reset
//   rs1_addr  in   5   read port 1 address
//   rs1_data  out  32  read port 1 data
//   rs2_addr  in   5   read port 2 address
//   rs2_data  out  32  read port 2 data
//   dbg_addr  in   5   debug read address
//   dbg_data  out  32  debug read data
//   wr_en     in   1   write enable
//   wr_addr   in   5   write address (writes to x0 are dropped)
//   wr_data   in   32  write data
// ----------------------------------------------------------------------------
module core_regfile
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr,
    output logic [31:0] rs1_data,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs2_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    localparam int NUM_RD_PORTS = 3;

    logic [31:0] regs [32];

    logic [4:0]  rd_addr [NUM_RD_PORTS];
    logic [31:0] rd_data [NUM_RD_PORTS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;
    assign rd_addr[2] = dbg_addr;

    // x0 is forced to zero on the read side as well, so correctness never
    // depends on regs[0] staying cleared.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd_port
            assign rd_data[gi] = (rd_addr[gi] == 5'd0) ? 32'd0 : regs[rd_addr[gi]];
        end
    endgenerate

    assign rs1_data = rd_data[0];
    assign rs2_data = rd_data[1];
    assign dbg_data = rd_data[2];

endmodule

// File: rtl/core_single.sv
// ----------------------------------------------------------------------------
// core_single
//   Single-cycle RV32I integer core (no loads/stores). Every rising edge the
//   instruction at pc is decoded, executed, written back and pc advanced.
//   Unsupported or malformed encodings retire as no-ops (pc + 4, no write).
// Parameters
//   RESET_PC  value loaded into pc while reset is asserted
// Ports
//   clk       in   1   clock
//   rst       in   1   asynchronous active-low reset
//   inst      in   32  instruction word at pc (combinational from imem)
//   pc        out  32  address of the instruction being executed
//   dbg_addr  in   5   register-file debug read address
//   dbg_data  out  32  x[dbg_addr], x0 reads 0
// ----------------------------------------------------------------------------
module core_single
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    output logic [31:0] pc,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    // ------------------------------------------------------------------
    // Immediate generation (B and J carry an implicit zero in bit 0)
    // ------------------------------------------------------------------
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] imm_b;
    logic [31:0] imm_j;

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_u = {inst[31:12], 12'd0};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;

    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rd_we;
    logic [31:0] rd_wdata;

    core_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1),
        .rs1_data (rs1_data),
        .rs2_addr (rs2),
        .rs2_data (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_en    (rd_we),
        .wr_addr  (rd),
        .wr_data  (rd_wdata)
    );

    // ------------------------------------------------------------------
    // Decode / execute
    // ------------------------------------------------------------------
    alu_op_e     alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_result;
    logic        link;
    logic        r_legal;
    logic        shift_imm_legal;
    logic [31:0] jalr_target;

    assign pc_plus4 = pc_reg + 32'd4;

    // R-type: funct7 must be all-zero, or the alternate pattern on ADD/SRL.
    assign r_legal = (funct7 == F7_BASE) ||
                     ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SR)));

    // Immediate shifts reuse imm[11:5] as funct7; SLLI has no alternate form.
    assign shift_imm_legal = (funct7 == F7_BASE) ||
                             ((funct7 == F7_ALT) && (funct3 == F3_SR));

    // rs1 is sampled before writeback, so JALR with rd == rs1 uses the old value.
    assign jalr_target = (rs1_data + imm_i) & ~32'd1;

    always_comb begin
        alu_op  = ALU_ADD;
        op_a    = rs1_data;
        op_b    = rs2_data;
        rd_we   = 1'b0;
        link    = 1'b0;
        pc_next = pc_plus4;

        case (opcode)
            OPC_OP: begin
                if (r_legal) begin
                    rd_we  = 1'b1;
                    alu_op = alu_op_from_f3(funct3, funct7[5]);
                end
            end

            OPC_OP_IMM: begin
                op_b = imm_i;
                if ((funct3 == F3_SLL) || (funct3 == F3_SR)) begin
                    if (shift_imm_legal) begin
                        rd_we  = 1'b1;
                        alu_op = alu_op_from_f3(funct3, funct7[5]);
                    end
                end else begin
                    // For ADDI, funct7[5] is an immediate bit, never SUB.
                    rd_we  = 1'b1;
                    alu_op = alu_op_from_f3(funct3, 1'b0);
                end
            end

            OPC_LUI: begin
                op_a  = 32'd0;
                op_b  = imm_u;
                rd_we = 1'b1;
            end

            OPC_AUIPC: begin
                op_a  = pc_reg;
                op_b  = imm_u;
                rd_we = 1'b1;
            end

            OPC_JAL: begin
                rd_we   = 1'b1;
                link    = 1'b1;
                pc_next = pc_reg + imm_j;
            end

            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    rd_we   = 1'b1;
                    link    = 1'b1;
                    pc_next = jalr_target;
                end
            end

            OPC_BRANCH: begin
                if ((funct3 != 3'b010) && (funct3 != 3'b011)) begin
                    if (branch_taken(funct3, rs1_data, rs2_data)) begin
                        pc_next = pc_reg + imm_b;
                    end
                end
            end

            default: begin
                // Loads, stores, FENCE, SYSTEM and garbage retire as no-ops.
            end
        endcase
    end

    assign alu_result = alu_exec(alu_op, op_a, op_b);
    assign rd_wdata   = link ? pc_plus4 : alu_result;

    // ------------------------------------------------------------------
    // Program counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc = pc_reg;

endmodule

// File: tb/tb_core_single.sv
// ----------------------------------------------------------------------------
// tb_core_single
//   Directed RV32I sequences followed by randomized instruction streams, each
//   checked against an instruction-level reference model (architectural
//   register array + pc) kept in the bench.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_core_single;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst = 32'd0;
    logic [31:0] pc;
    logic [4:0]  dbg_addr = 5'd0;
    logic [31:0] dbg_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ref_x [32];
    logic [31:0] ref_pc;

    always #5 clk = ~clk;

    core_single #(.RESET_PC(32'h0000_0000)) dut (
        .clk      (clk),
        .rst      (rst),
        .inst     (inst),
        .pc       (pc),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic reg_check(input string tag, input int addr, input logic [31:0] exp);
        dbg_addr = 5'(addr);
        #0.1;
        check(tag, dbg_data, exp);
    endtask

    // ------------------------------------------------------------------
    // Encoders
    // ------------------------------------------------------------------
    localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LUI = 7'h37, OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_JAL = 7'h6F, OP_JALR = 7'h67, OP_BR = 7'h63;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], OP_BR};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, OP_JAL};
    endfunction

    // ------------------------------------------------------------------
    // Reference model: one architectural step per instruction
    // ------------------------------------------------------------------
    task automatic model_reset();
        for (int i = 0; i < 32; i++) ref_x[i] = 32'd0;
        ref_pc = 32'd0;
    endtask

    task automatic model_exec(input logic [31:0] w);
        logic [31:0] a, b, imm, res, npc;
        logic signed [31:0] sa;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] sh;
        bit wr;
        bit legal;
        bit take;
        a   = ref_x[w[19:15]];
        b   = ref_x[w[24:20]];
        f3  = w[14:12];
        f7  = w[31:25];
        npc = ref_pc + 32'd4;
        res = 32'd0;
        wr  = 0;
        case (w[6:0])
            OP_R, OP_I: begin
                if (w[6:0] == OP_I) b = {{20{w[31]}}, w[31:20]};
                sh = b[4:0];
                if (w[6:0] == OP_R)
                    legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                else if (f3 == 1 || f3 == 5)
                    legal = (f7 == 0) || (f7 == 7'h20 && f3 == 5);
                else
                    legal = 1;
                wr = legal;
                case (f3)
                    3'd0: res = (w[6:0] == OP_R && f7[5]) ? a - b : a + b;
                    3'd1: res = a << sh;
                    3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: res = (a < b) ? 32'd1 : 32'd0;
                    3'd4: res = a ^ b;
                    3'd5: begin
                        if (f7[5]) begin
                            sa  = a;
                            sa  = sa >>> sh;
                            res = sa;
                        end else begin
                            res = a >> sh;
                        end
                    end
                    3'd6: res = a | b;
                    default: res = a & b;
                endcase
            end
            OP_LUI: begin
                res = {w[31:12], 12'd0};
                wr  = 1;
            end
            OP_AUIPC: begin
                res = ref_pc + {w[31:12], 12'd0};
                wr  = 1;
            end
            OP_JAL: begin
                imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                res = ref_pc + 32'd4;
                npc = ref_pc + imm;
                wr  = 1;
            end
            OP_JALR: begin
                if (f3 == 0) begin
                    imm = {{20{w[31]}}, w[31:20]};
                    res = ref_pc + 32'd4;
                    npc = (a + imm) & 32'hFFFF_FFFE;
                    wr  = 1;
                end
            end
            OP_BR: begin
                imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                case (f3)
                    3'd0: take = (a == b);
                    3'd1: take = (a != b);
                    3'd4: take = ($signed(a) < $signed(b));
                    3'd5: take = ($signed(a) >= $signed(b));
                    3'd6: take = (a < b);
                    3'd7: take = (a >= b);
                    default: take = 0;
                endcase
                if (take) npc = ref_pc + imm;
            end
            default: ;
        endcase
        if (wr && w[11:7] != 5'd0) ref_x[w[11:7]] = res;
        ref_pc = npc;
    endtask

    // ------------------------------------------------------------------
    // Drive one instruction (called just after a falling edge); returns
    // just after the next falling edge.
    // ------------------------------------------------------------------
    task automatic run_inst(input logic [31:0] w);
        logic [31:0] old_pc;
        logic [4:0]  probe;
        old_pc = ref_pc;
        inst = w;
        model_exec(w);
        @(posedge clk);
        #1;
        check("pc", pc, ref_pc);
        dbg_addr = w[11:7];
        #1;
        check("rd", dbg_data, ref_x[w[11:7]]);
        probe = 5'($urandom_range(0, 31));
        dbg_addr = probe;
        #1;
        check("probe", dbg_data, ref_x[probe]);
        $display("[TB] pc=%08h inst=%08h next_pc=%08h rd=x%0d", old_pc, w, pc, w[11:7]);
        @(negedge clk);
    endtask

    task automatic sweep_regs();
        for (int i = 0; i < 32; i++) reg_check("sweep", i, ref_x[i]);
    endtask

    // ------------------------------------------------------------------
    // Random instruction generator (mostly legal, some malformed)
    // ------------------------------------------------------------------
    function automatic logic [31:0] rand_inst();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm12;
        int kind;
        rd    = 5'($urandom_range(0, 31));
        rs1   = 5'($urandom_range(0, 31));
        rs2   = 5'($urandom_range(0, 31));
        f3    = 3'($urandom_range(0, 7));
        imm12 = 12'($urandom);
        kind  = $urandom_range(0, 11);
        case (kind)
            0, 1: begin
                f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return enc_r(f7, rs2, rs1, f3, rd);
            end
            2: begin
                case ($urandom_range(0, 2))
                    0: f7 = 7'h00;
                    1: f7 = 7'h20;
                    default: f7 = 7'($urandom);
                endcase
                return enc_r(f7, rs2, rs1, f3, rd);
            end
            3, 4: begin
                if (f3 == 1 || f3 == 5) f3 = 3'd0;
                return enc_i(imm12, rs1, f3, rd, OP_I);
            end
            5: begin
                f3 = ($urandom_range(0, 1) == 1) ? 3'd5 : 3'd1;
                case ($urandom_range(0, 3))
                    0, 1: f7 = 7'h00;
                    2: f7 = 7'h20;
                    default: f7 = 7'($urandom);
                endcase
                return {f7, 5'($urandom), rs1, f3, rd, OP_I};
            end
            6: return {20'($urandom), rd, ($urandom_range(0, 1) == 1) ? OP_LUI : OP_AUIPC};
            7: return enc_j(21'($urandom) & 21'h1FFFFE, rd);
            8: begin
                f3 = ($urandom_range(0, 3) == 0) ? f3 : 3'd0;
                return enc_i(imm12, rs1, f3, rd, OP_JALR);
            end
            9, 10: begin
                if ($urandom_range(0, 2) == 0) rs2 = rs1;
                return enc_b(13'($urandom) & 13'h1FFE, rs2, rs1, f3);
            end
            default: return $urandom;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_pc", pc, 32'd0);
        reg_check("reset_x18", 18, 32'd0);
        rst = 1'b1;

        // ADD sequence
        run_inst(enc_i(12'd7, 5'd0, 3'd0, 5'd19, OP_I));
        run_inst(enc_i(12'd5, 5'd0, 3'd0, 5'd10, OP_I));
        run_inst(32'h00A98933);
        reg_check("add_x18", 18, 32'd12);
        check("add_pc", pc, 32'd12);

        // SUB / SLT / SLTU with x1 = -1
        run_inst(enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, OP_I));
        run_inst(enc_r(7'h00, 5'd1, 5'd0, 3'b011, 5'd2));
        run_inst(enc_r(7'h00, 5'd0, 5'd1, 3'b010, 5'd3));
        run_inst(enc_r(7'h20, 5'd1, 5'd0, 3'b000, 5'd4));
        reg_check("sltu_x2", 2, 32'd1);
        reg_check("slt_x3", 3, 32'd1);
        reg_check("sub_x4", 4, 32'd1);
        check("seq_pc", pc, 32'h1C);

        // BNE not taken, JAL, JALR, BEQ taken
        run_inst(enc_b(13'd8, 5'd0, 5'd0, 3'b001));
        check("bne_pc", pc, 32'h20);
        run_inst(enc_j(21'h100, 5'd1));
        check("jal_pc", pc, 32'h120);
        reg_check("jal_x1", 1, 32'h24);
        run_inst(enc_i(12'd1, 5'd1, 3'd0, 5'd0, OP_JALR));
        check("jalr_pc", pc, 32'h24);
        run_inst(enc_b(13'd8, 5'd0, 5'd0, 3'b000));
        check("beq_pc", pc, 32'h2C);

        // All-zero word and write to x0
        run_inst(32'h0000_0000);
        check("nop_pc", pc, 32'h30);
        run_inst(enc_i(12'd5, 5'd0, 3'd0, 5'd0, OP_I));
        reg_check("x0_zero", 0, 32'd0);
        check("x0w_pc", pc, 32'h34);
        reg_check("x18_kept", 18, 32'd12);
        sweep_regs();

        // Random stream
        for (int n = 0; n < 300; n++) begin
            run_inst(rand_inst());
            if (n % 50 == 49) sweep_regs();
        end

        // Reset mid-run while a register-writing instruction is presented
        inst = enc_i(12'd9, 5'd0, 3'd0, 5'd5, OP_I);
        rst  = 1'b0;
        #1;
        check("rst_pc_now", pc, 32'd0);
        for (int i = 0; i < 32; i++) reg_check("rst_reg", i, 32'd0);
        @(posedge clk);
        #1;
        check("rst_pc_hold", pc, 32'd0);
        reg_check("rst_x5_discard", 5, 32'd0);
        @(negedge clk);
        model_reset();
        rst = 1'b1;

        // Resume after reset
        run_inst(enc_i(12'h123, 5'd0, 3'd0, 5'd7, OP_I));
        reg_check("post_rst_x7", 7, 32'h123);
        check("post_rst_pc", pc, 32'd4);
        for (int n = 0; n < 150; n++) run_inst(rand_inst());
        sweep_regs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
